// File: rtl/vc_dest_arbiter.sv
// Weighted round-robin pop scheduler between two VC FIFOs. The popped word is
// captured and routed by bit 4 to one of two destination FIFOs through a registered push.
module vc_dest_arbiter #(
    parameter int DATA_W = 6,
    parameter int CNT_W  = 8
) (
    input  logic              clk,
    input  logic              RESET_L,
    input  logic              ACTIVE,
    input  logic [2:0]        VC0_WEIGHT,
    input  logic [2:0]        VC1_WEIGHT,
    input  logic              VC0_EMPTY,
    input  logic              VC1_EMPTY,
    input  logic              VC0_VALID,
    input  logic              VC1_VALID,
    input  logic [DATA_W-1:0] DATA_OUT_VC0,
    input  logic [DATA_W-1:0] DATA_OUT_VC1,
    input  logic              D0_PAUSE,
    input  logic              D1_PAUSE,
    input  logic              D0_FULL,
    input  logic              D1_FULL,
    output logic              POP_VC0,
    output logic              POP_VC1,
    output logic              PUSH_D0,
    output logic              PUSH_D1,
    output logic [DATA_W-1:0] DATA_TO_D0,
    output logic [DATA_W-1:0] DATA_TO_D1,
    output logic              GRANT,
    output logic [2:0]        ERR,
    output logic [CNT_W-1:0]  CNT_D0,
    output logic [CNT_W-1:0]  CNT_D1
);
    typedef enum logic [1:0] {IDLE, SERVE0, SERVE1} state_t;

    state_t      state_q, state_d;
    logic [2:0]  credit_q, credit_d;
    logic        grant_q, grant_d;
    logic        first_q, first_d;
    logic        pop0_q, pop1_q;
    logic        pop_en, pop_sel;
    logic        stall, cur, cur_empty, oth_empty;
    logic [2:0]  load0, load1;

    // Both pauses gate every pop: the destination is only known after the read.
    assign stall     = ~ACTIVE | D0_PAUSE | D1_PAUSE;
    assign load0     = (VC0_WEIGHT == 3'd0) ? 3'd1 : VC0_WEIGHT;
    assign load1     = (VC1_WEIGHT == 3'd0) ? 3'd1 : VC1_WEIGHT;
    assign cur       = (state_q == SERVE1);
    assign cur_empty = cur ? VC1_EMPTY : VC0_EMPTY;
    assign oth_empty = cur ? VC0_EMPTY : VC1_EMPTY;

    always_ff @(posedge clk) begin
        if (!RESET_L) begin
            state_q  <= IDLE;
            credit_q <= 3'd0;
            grant_q  <= 1'b0;
            first_q  <= 1'b1;
            pop0_q   <= 1'b0;
            pop1_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            credit_q <= credit_d;
            grant_q  <= grant_d;
            first_q  <= first_d;
            pop0_q   <= POP_VC0;
            pop1_q   <= POP_VC1;
        end
    end

    always_comb begin
        state_d  = state_q;
        credit_d = credit_q;
        grant_d  = grant_q;
        first_d  = first_q;
        pop_en   = 1'b0;
        pop_sel  = grant_q;
        if (RESET_L) begin
            case (state_q)
                IDLE: begin
                    if (!stall && !(VC0_EMPTY && VC1_EMPTY)) begin
                        if (VC1_EMPTY)      pop_sel = 1'b0;
                        else if (VC0_EMPTY) pop_sel = 1'b1;
                        else                pop_sel = first_q ? 1'b0 : ~grant_q;
                        pop_en   = 1'b1;
                        grant_d  = pop_sel;
                        credit_d = (pop_sel ? load1 : load0) - 3'd1;
                        state_d  = pop_sel ? SERVE1 : SERVE0;
                    end
                end
                SERVE0, SERVE1: begin
                    if (!ACTIVE || (VC0_EMPTY && VC1_EMPTY)) begin
                        state_d = IDLE;
                    end else if (!stall) begin
                        pop_en = 1'b1;
                        if ((credit_q == 3'd0 || cur_empty) && !oth_empty) begin
                            pop_sel  = ~cur;
                            grant_d  = ~cur;
                            credit_d = (~cur ? load1 : load0) - 3'd1;
                            state_d  = ~cur ? SERVE1 : SERVE0;
                        end else if (credit_q == 3'd0) begin
                            // Budget spent but the other VC has nothing: renew our own.
                            pop_sel  = cur;
                            credit_d = (cur ? load1 : load0) - 3'd1;
                        end else begin
                            pop_sel  = cur;
                            credit_d = credit_q - 3'd1;
                        end
                    end
                end
                default: state_d = IDLE;
            endcase
            if (pop_en) first_d = 1'b0;
        end
    end

    always_comb begin
        POP_VC0 = pop_en & ~pop_sel;
        POP_VC1 = pop_en & pop_sel;
        GRANT   = grant_d;
    end

    // Capture: VC0 wins if both report valid (only possible alongside ERR[0]).
    logic              any_valid, src_vc, dest, dest_full, push_ok;
    logic [DATA_W-1:0] word;
    logic [2:0]        err_q, err_d;

    assign any_valid = VC0_VALID | VC1_VALID;
    assign src_vc    = ~VC0_VALID;
    assign word      = VC0_VALID ? DATA_OUT_VC0 : DATA_OUT_VC1;
    assign dest      = word[4];
    assign dest_full = dest ? D1_FULL : D0_FULL;
    assign push_ok   = any_valid & ~dest_full;
    assign err_d     = err_q | {any_valid & (word[5] != src_vc),
                                any_valid & dest_full,
                                (VC0_VALID & ~pop0_q) | (VC1_VALID & ~pop1_q)};

    always_ff @(posedge clk) begin
        if (!RESET_L) err_q <= 3'd0;
        else          err_q <= err_d;
    end
    assign ERR = err_q;

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_dest
            logic              hit;
            logic              push_q;
            logic [DATA_W-1:0] data_q;
            logic [CNT_W-1:0]  cnt_q;

            assign hit = push_ok & (dest == (gi == 1));

            always_ff @(posedge clk) begin
                if (!RESET_L) begin
                    push_q <= 1'b0;
                    data_q <= '0;
                    cnt_q  <= '0;
                end else begin
                    push_q <= hit;
                    if (hit) begin
                        data_q <= word;
                        cnt_q  <= cnt_q + CNT_W'(1);
                    end
                end
            end
        end
    endgenerate

    assign PUSH_D0    = g_dest[0].push_q;
    assign PUSH_D1    = g_dest[1].push_q;
    assign DATA_TO_D0 = g_dest[0].data_q;
    assign DATA_TO_D1 = g_dest[1].data_q;
    assign CNT_D0     = g_dest[0].cnt_q;
    assign CNT_D1     = g_dest[1].cnt_q;
endmodule

// File: tb/tb_vc_dest_arbiter.sv
// Directed bench for vc_dest_arbiter: a queue model stands in for the VC FIFOs,
// and each scenario compares pops, pushes, data, counters and error flags per cycle.
module tb_vc_dest_arbiter;
    logic       clk = 1'b0;
    logic       RESET_L, ACTIVE;
    logic [2:0] VC0_WEIGHT, VC1_WEIGHT;
    logic       VC0_EMPTY, VC1_EMPTY, VC0_VALID, VC1_VALID;
    logic [5:0] DATA_OUT_VC0, DATA_OUT_VC1;
    logic       D0_PAUSE, D1_PAUSE, D0_FULL, D1_FULL;
    logic       POP_VC0, POP_VC1, PUSH_D0, PUSH_D1, GRANT;
    logic [5:0] DATA_TO_D0, DATA_TO_D1;
    logic [2:0] ERR;
    logic [7:0] CNT_D0, CNT_D1;

    int n_vec = 0;
    int n_err = 0;

    logic [5:0] q0[$];
    logic [5:0] q1[$];
    logic       s_pop0, s_pop1, s_push0, s_push1, s_grant;
    logic [5:0] s_data0, s_data1;
    logic [2:0] s_err;
    logic [7:0] s_cnt0, s_cnt1;

    vc_dest_arbiter #(.DATA_W(6), .CNT_W(8)) dut (
        .clk(clk), .RESET_L(RESET_L), .ACTIVE(ACTIVE),
        .VC0_WEIGHT(VC0_WEIGHT), .VC1_WEIGHT(VC1_WEIGHT),
        .VC0_EMPTY(VC0_EMPTY), .VC1_EMPTY(VC1_EMPTY),
        .VC0_VALID(VC0_VALID), .VC1_VALID(VC1_VALID),
        .DATA_OUT_VC0(DATA_OUT_VC0), .DATA_OUT_VC1(DATA_OUT_VC1),
        .D0_PAUSE(D0_PAUSE), .D1_PAUSE(D1_PAUSE),
        .D0_FULL(D0_FULL), .D1_FULL(D1_FULL),
        .POP_VC0(POP_VC0), .POP_VC1(POP_VC1),
        .PUSH_D0(PUSH_D0), .PUSH_D1(PUSH_D1),
        .DATA_TO_D0(DATA_TO_D0), .DATA_TO_D1(DATA_TO_D1),
        .GRANT(GRANT), .ERR(ERR), .CNT_D0(CNT_D0), .CNT_D1(CNT_D1)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    // One clock: sample at negedge, then let the FIFO model answer the pops.
    task automatic cycle();
        @(negedge clk);
        s_pop0 = POP_VC0;  s_pop1 = POP_VC1;  s_grant = GRANT;
        s_push0 = PUSH_D0; s_push1 = PUSH_D1;
        s_data0 = DATA_TO_D0; s_data1 = DATA_TO_D1;
        s_err = ERR; s_cnt0 = CNT_D0; s_cnt1 = CNT_D1;
        @(posedge clk);
        #1;
        VC0_VALID = s_pop0;
        VC1_VALID = s_pop1;
        if (s_pop0 && q0.size() > 0) DATA_OUT_VC0 = q0.pop_front();
        if (s_pop1 && q1.size() > 0) DATA_OUT_VC1 = q1.pop_front();
        VC0_EMPTY = (q0.size() == 0);
        VC1_EMPTY = (q1.size() == 0);
    endtask

    task automatic do_reset();
        RESET_L = 1'b0; ACTIVE = 1'b1;
        q0.delete(); q1.delete();
        VC0_VALID = 1'b0; VC1_VALID = 1'b0;
        VC0_EMPTY = 1'b1; VC1_EMPTY = 1'b1;
        DATA_OUT_VC0 = 6'h00; DATA_OUT_VC1 = 6'h00;
        D0_PAUSE = 1'b0; D1_PAUSE = 1'b0; D0_FULL = 1'b0; D1_FULL = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        RESET_L = 1'b1;
    endtask

    task automatic sync_empty();
        VC0_EMPTY = (q0.size() == 0);
        VC1_EMPTY = (q1.size() == 0);
    endtask

    task automatic test_reset();
        logic [31:0] got;
        VC0_WEIGHT = 3'd1; VC1_WEIGHT = 3'd1;
        do_reset();
        got = {3'b0, PUSH_D0, PUSH_D1, POP_VC0, POP_VC1, GRANT, ERR, CNT_D0, CNT_D1, 3'b0};
        n_vec++;
        if (got !== 32'h0) begin
            n_err++;
            $display("FAIL reset_ctrl: got %h expected 00000000", got);
        end
        n_vec++;
        if ({DATA_TO_D0, DATA_TO_D1} !== 12'h000) begin
            n_err++;
            $display("FAIL reset_data: got %h expected 000", {DATA_TO_D0, DATA_TO_D1});
        end
        $display("test_reset: outputs checked after reset");
    endtask

    task automatic test_basic_route();
        logic [3:0] exp[4] = '{4'b1000, 4'b1000, 4'b0010, 4'b0001};
        VC0_WEIGHT = 3'd2; VC1_WEIGHT = 3'd1;
        do_reset();
        q0.push_back(6'h05); q0.push_back(6'h15); sync_empty();
        for (int c = 0; c < 4; c++) begin
            cycle();
            n_vec++;
            if ({s_pop0, s_pop1, s_push0, s_push1} !== exp[c]) begin
                n_err++;
                $display("FAIL basic_ctl cyc%0d: got %b expected %b", c + 1, {s_pop0, s_pop1, s_push0, s_push1}, exp[c]);
            end
            if (c == 2) begin
                n_vec++;
                if (s_data0 !== 6'h05) begin
                    n_err++;
                    $display("FAIL basic_d0: got %h expected 05", s_data0);
                end
            end
            $display("basic cyc%0d pop=%b%b push=%b%b", c + 1, s_pop0, s_pop1, s_push0, s_push1);
        end
        n_vec++;
        if ({s_data1, s_cnt0, s_cnt1} !== {6'h15, 8'd1, 8'd1}) begin
            n_err++;
            $display("FAIL basic_d1_cnt: got %h/%0d/%0d expected 15/1/1", s_data1, s_cnt0, s_cnt1);
        end
    endtask

    task automatic test_wrr();
        logic [1:0] exp_pop[9] = '{2'b10, 2'b10, 2'b01, 2'b10, 2'b10, 2'b01, 2'b01, 2'b01, 2'b00};
        logic       exp_gnt[9] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
        VC0_WEIGHT = 3'd2; VC1_WEIGHT = 3'd1;
        do_reset();
        for (int i = 0; i < 4; i++) begin
            q0.push_back(6'(i));
            q1.push_back(6'(32 + i));
        end
        sync_empty();
        for (int c = 0; c < 9; c++) begin
            cycle();
            n_vec++;
            if ({s_pop0, s_pop1} !== exp_pop[c]) begin
                n_err++;
                $display("FAIL wrr_pop cyc%0d: got %b expected %b", c + 1, {s_pop0, s_pop1}, exp_pop[c]);
            end
            n_vec++;
            if (s_grant !== exp_gnt[c]) begin
                n_err++;
                $display("FAIL wrr_grant cyc%0d: got %b expected %b", c + 1, s_grant, exp_gnt[c]);
            end
            $display("wrr cyc%0d pop=%b%b grant=%b", c + 1, s_pop0, s_pop1, s_grant);
        end
        cycle(); cycle();
        n_vec++;
        if ({s_cnt0, s_cnt1} !== {8'd8, 8'd0}) begin
            n_err++;
            $display("FAIL wrr_cnt: got %0d/%0d expected 8/0", s_cnt0, s_cnt1);
        end
    endtask

    task automatic test_pause();
        logic [3:0] exp[8] = '{4'b1000, 4'b1000, 4'b0010, 4'b0010,
                               4'b0000, 4'b1000, 4'b0100, 4'b1010};
        logic [5:0] exp_d[8] = '{6'h00, 6'h00, 6'h01, 6'h02, 6'h02, 6'h02, 6'h02, 6'h03};
        VC0_WEIGHT = 3'd3; VC1_WEIGHT = 3'd1;
        do_reset();
        for (int i = 1; i <= 5; i++) q0.push_back(6'(i));
        q1.push_back(6'h21);
        sync_empty();
        for (int c = 0; c < 8; c++) begin
            if (c == 2) D1_PAUSE = 1'b1;
            if (c == 5) D1_PAUSE = 1'b0;
            cycle();
            n_vec++;
            if ({s_pop0, s_pop1, s_push0, s_push1} !== exp[c]) begin
                n_err++;
                $display("FAIL pause_ctl cyc%0d: got %b expected %b", c + 1, {s_pop0, s_pop1, s_push0, s_push1}, exp[c]);
            end
            if (exp[c][1]) begin
                n_vec++;
                if (s_data0 !== exp_d[c]) begin
                    n_err++;
                    $display("FAIL pause_data cyc%0d: got %h expected %h", c + 1, s_data0, exp_d[c]);
                end
            end
            $display("pause cyc%0d pop=%b%b push0=%b data0=%h", c + 1, s_pop0, s_pop1, s_push0, s_data0);
        end
    endtask

    task automatic test_err_valid();
        VC0_WEIGHT = 3'd1; VC1_WEIGHT = 3'd1;
        do_reset();
        VC1_VALID = 1'b1; DATA_OUT_VC1 = 6'h30;
        cycle(); cycle();
        n_vec++;
        if (s_err !== 3'b001) begin
            n_err++;
            $display("FAIL err0_set: got %b expected 001", s_err);
        end
        repeat (3) cycle();
        n_vec++;
        if (s_err !== 3'b001) begin
            n_err++;
            $display("FAIL err0_sticky: got %b expected 001", s_err);
        end
        do_reset();
        n_vec++;
        if (ERR !== 3'b000) begin
            n_err++;
            $display("FAIL err0_clear: got %b expected 000", ERR);
        end
        VC0_VALID = 1'b1; DATA_OUT_VC0 = 6'h01;
        VC1_VALID = 1'b1; DATA_OUT_VC1 = 6'h31;
        cycle(); cycle();
        n_vec++;
        if ({s_push0, s_push1, s_data0, s_err} !== {1'b1, 1'b0, 6'h01, 3'b001}) begin
            n_err++;
            $display("FAIL both_valid: got %b%b %h %b expected 10 01 001", s_push0, s_push1, s_data0, s_err);
        end
        $display("err_valid: err=%b push=%b%b", s_err, s_push0, s_push1);
    endtask

    task automatic test_full_drop();
        VC0_WEIGHT = 3'd1; VC1_WEIGHT = 3'd1;
        do_reset();
        D1_FULL = 1'b1;
        q0.push_back(6'h10); sync_empty();
        for (int c = 0; c < 4; c++) begin
            cycle();
            n_vec++;
            if (s_push1 !== 1'b0 || s_push0 !== 1'b0) begin
                n_err++;
                $display("FAIL full_push cyc%0d: got %b%b expected 00", c + 1, s_push0, s_push1);
            end
            $display("full cyc%0d pop0=%b push1=%b err=%b", c + 1, s_pop0, s_push1, s_err);
        end
        n_vec++;
        if ({s_cnt1, s_err} !== {8'd0, 3'b010}) begin
            n_err++;
            $display("FAIL full_cnt_err: got %0d/%b expected 0/010", s_cnt1, s_err);
        end
    endtask

    task automatic test_vcid_weight0();
        logic [3:0] exp[5] = '{4'b1000, 4'b0100, 4'b1010, 4'b0010, 4'b0010};
        logic [5:0] exp_d[5] = '{6'h00, 6'h00, 6'h25, 6'h20, 6'h02};
        VC0_WEIGHT = 3'd0; VC1_WEIGHT = 3'd0;
        do_reset();
        q0.push_back(6'h25); q0.push_back(6'h02);
        q1.push_back(6'h20);
        sync_empty();
        for (int c = 0; c < 5; c++) begin
            cycle();
            n_vec++;
            if ({s_pop0, s_pop1, s_push0, s_push1} !== exp[c]) begin
                n_err++;
                $display("FAIL vcid_ctl cyc%0d: got %b expected %b", c + 1, {s_pop0, s_pop1, s_push0, s_push1}, exp[c]);
            end
            if (exp[c][1]) begin
                n_vec++;
                if (s_data0 !== exp_d[c]) begin
                    n_err++;
                    $display("FAIL vcid_data cyc%0d: got %h expected %h", c + 1, s_data0, exp_d[c]);
                end
            end
            $display("vcid cyc%0d pop=%b%b push0=%b data0=%h err=%b", c + 1, s_pop0, s_pop1, s_push0, s_data0, s_err);
        end
        n_vec++;
        if ({s_err, s_cnt0} !== {3'b100, 8'd3}) begin
            n_err++;
            $display("FAIL vcid_err_cnt: got %b/%0d expected 100/3", s_err, s_cnt0);
        end
    endtask

    initial begin
        test_reset();
        test_basic_route();
        test_wrr();
        test_pause();
        test_err_valid();
        test_full_drop();
        test_vcid_weight0();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/vc_dest_arbiter.md
Name: vc_dest_arbiter

Overview:
- Scheduler between the two virtual-channel FIFOs (VC0, VC1) and the two destination FIFOs (D0, D1) of the transmitter.
- Issues at most one pop per cycle using weighted round-robin.
- Captures the popped word and routes it by bit 4 (0 → D0, 1 → D1) with a registered push.
- Throttles on destination pause and flags protocol errors.

Parameters:
- DATA_W, 6, word width; bit 5 = VC id, bit 4 = destination select.
- CNT_W, 8, width of the per-destination push counters.

Ports:
- clk  input  1  clock
- RESET_L  input  1  synchronous active-low reset
- ACTIVE  input  1  FSM active; new pops are allowed only while high
- VC0_WEIGHT  input  3  consecutive-grant budget for VC0; 0 is treated as 1
- VC1_WEIGHT  input  3  consecutive-grant budget for VC1; 0 is treated as 1
- VC0_EMPTY  input  1  VC0 FIFO empty
- VC1_EMPTY  input  1  VC1 FIFO empty
- VC0_VALID  input  1  VC0 read data valid, one cycle after a pop
- VC1_VALID  input  1  VC1 read data valid, one cycle after a pop
- DATA_OUT_VC0  input  DATA_W  VC0 read data
- DATA_OUT_VC1  input  DATA_W  VC1 read data
- D0_PAUSE  input  1  D0 almost-full
- D1_PAUSE  input  1  D1 almost-full
- D0_FULL  input  1  D0 full
- D1_FULL  input  1  D1 full
- POP_VC0  output  1  pop request to VC0, combinational
- POP_VC1  output  1  pop request to VC1, combinational
- PUSH_D0  output  1  push to D0, registered
- PUSH_D1  output  1  push to D1, registered
- DATA_TO_D0  output  DATA_W  write data to D0, registered
- DATA_TO_D1  output  DATA_W  write data to D1, registered
- GRANT  output  1  VC currently served (0 = VC0, 1 = VC1)
- ERR  output  3  sticky error flags
- CNT_D0  output  CNT_W  wrapping count of words pushed to D0
- CNT_D1  output  CNT_W  wrapping count of words pushed to D1

Behaviour:
- Reset (RESET_L low at a clk edge):
  - state = IDLE; GRANT = 0; credit = 0.
  - PUSH_D0/PUSH_D1 = 0; DATA_TO_D0/DATA_TO_D1 = 0; ERR = 0; CNT_D0/CNT_D1 = 0.
  - In-flight tracking flags are cleared.
  - Valid data arriving during reset is discarded.
- Pop gating: stall = ~ACTIVE | D0_PAUSE | D1_PAUSE. The destination is unknown before the read, so both pauses gate every pop. PAUSE thresholds must leave at least 2 free entries (pop→push latency = 2).
- States: IDLE, SERVE0, SERVE1.
  - IDLE:
    - If ~stall and exactly one VC is non-empty → serve that VC.
    - If both VCs are non-empty → serve the VC opposite to the last GRANT; after reset VC0 goes first.
    - Entering a SERVEx state: load credit = max(weight, 1), set GRANT = x, and pop in that same cycle.
  - SERVEx:
    - POP_VCx = ~stall & ~VCx_EMPTY. Each pop decrements credit.
    - Switch to the other VC (reloading its credit) when credit reaches 0, or VCx is empty, and the other VC is non-empty.
    - Go to IDLE when both VCs are empty or ACTIVE is low.
    - While stalled with credit remaining, stay in SERVEx and hold credit.
  - POP_VC0 and POP_VC1 are never high in the same cycle.
- Data path:
  - A VCx_VALID at cycle t produces a registered push at t+1.
  - Destination = DATA_OUT_VCx[4].
  - Unselected DATA_TO_Dx holds its previous value.
- Error bits (sticky until reset):
  - ERR[0]: VCx_VALID without a POP_VCx in the previous cycle.
  - ERR[1]: push target Dx has FULL high. The word is dropped, no push is issued, and the counter is not incremented.
  - ERR[2]: word bit 5 ≠ source VC index. The word is still routed.
- Simultaneous VC0_VALID and VC1_VALID can only occur with ERR[0]. Then only VC0's word is pushed, and ERR[0] is set.
- Counters increment on every issued push and wrap modulo 2^CNT_W.
- ACTIVE falling: no new pops. Words already in flight complete their pushes.
- Reset mid-operation: an in-flight word is lost. No push is issued in the cycle after reset is released.

Test Plan:
- Reset, then VC0 holds 0x05 and 0x15, VC1 empty, ACTIVE = 1 → POP_VC0 in cycles 1 and 2. PUSH_D0 with DATA 0x05 at cycle 3; PUSH_D1 with DATA 0x15 at cycle 4. CNT_D0 = 1, CNT_D1 = 1.
- Both VCs hold 4 words, VC0_WEIGHT = 2, VC1_WEIGHT = 1 → pop order 0,0,1,0,0,1,… GRANT tracks the order; no cycle has both pops high.
- D1_PAUSE raised mid-burst → pops stop the next cycle. The 2 in-flight words are still pushed. Pops resume with the remaining credit once pause drops.
- VC1_VALID forced with no prior pop → ERR = 3'b001, held until RESET_L low.
- Word 0x10 read while D1_FULL = 1 → no PUSH_D1, CNT_D1 unchanged, ERR[1] = 1.
- VC0 holds word 0x25 (bit 5 = 1) → routed to D0, ERR[2] = 1. Weight 0 behaves as weight 1.
